// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       link_wb;
    logic       sel_regdst;
    logic       sel_jal;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, link_wb, sel_regdst, sel_jal, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, link_wb, sel_regdst, sel_jal, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore main control FSM for the multicycle MIPS core; the only Mealy terms are
// ir_write/pc_write in FETCH, which follow mem_ready so a stalled fetch never loads.
module mips_multicycle_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next state and output decode; everything is held at zero while rst is high.
    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.link_wb       = 1'b0;
        bus.sel_regdst    = 1'b0;
        bus.sel_jal       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_src        = 2'b00;
        bus.illegal       = 1'b0;
        bus.state         = 4'd0;
        if (!rst) begin
            bus.state = 4'(state_q);
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    if (bus.mem_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b11;
                    case (bus.opcode)
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    // A changed opcode here that is neither lw nor sw is flagged, not guessed.
                    if (bus.opcode == OP_LW)      state_d = S_MEMRD;
                    else if (bus.opcode == OP_SW) state_d = S_MEMWR;
                    else                          state_d = S_ILLEGAL;
                end
                S_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    if (bus.mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    state_d        = S_FETCH;
                end
                S_MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                    if (bus.mem_ready) state_d = S_FETCH;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                    state_d       = S_ALUWB;
                end
                S_ALUWB: begin
                    bus.reg_write  = 1'b1;
                    bus.sel_regdst = 1'b1;
                    state_d        = S_FETCH;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_src        = 2'b01;
                    state_d           = S_FETCH;
                end
                S_ADDIEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    state_d       = S_ADDIWB;
                end
                S_ADDIWB: begin
                    bus.reg_write = 1'b1;
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b10;
                    state_d      = S_FETCH;
                end
                // PC already holds PC+4 here, so it is the correct link value.
                S_JAL: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_src    = 2'b10;
                    bus.reg_write = 1'b1;
                    bus.sel_jal   = 1'b1;
                    bus.link_wb   = 1'b1;
                    state_d       = S_FETCH;
                end
                S_ILLEGAL: begin
                    bus.illegal = 1'b1;
                    state_d     = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction state walks and strobe checks.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] all_outs();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.link_wb, bus.sel_regdst, bus.sel_jal,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                bus.illegal, bus.state};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry and exit of every scenario: 1 time unit after an edge, DUT in FETCH.
    task automatic test_reset();
        rst = 1'b1; bus.opcode = 6'b000000; bus.mem_ready = 1'b1;
        tick(); tick();
        total++;
        if (all_outs() !== 23'd0) begin
            $display("FAIL reset_outs got=%h want=0", all_outs()); bad++;
        end
        rst = 1'b0; #1;
        total++;
        if (bus.state !== 4'd0 || bus.mem_read !== 1'b1 || bus.ir_write !== 1'b1) begin
            $display("FAIL reset_release state=%0d mem_read=%b ir_write=%b want 0/1/1",
                     bus.state, bus.mem_read, bus.ir_write); bad++;
        end
        // Walk into EXEC, then reset for two cycles.
        tick(); tick();
        total++;
        if (bus.state !== 4'd6) begin
            $display("FAIL reset_reach_exec state=%0d want=6", bus.state); bad++;
        end
        rst = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (all_outs() !== 23'd0) begin
                $display("FAIL reset_mid_exec cyc=%0d got=%h want=0", i, all_outs()); bad++;
            end
            tick();
        end
        rst = 1'b0; #1;
        total++;
        if (bus.state !== 4'd0 || bus.mem_read !== 1'b1) begin
            $display("FAIL reset_mid_exec_release state=%0d mem_read=%b want 0/1",
                     bus.state, bus.mem_read); bad++;
        end
    endtask

    // Opcode flips to lw after DECODE; only the DECODE sample may steer.
    task automatic test_rtype();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = 1'b1;
            bus.opcode    = (i == 1) ? 6'b000000 : 6'b100011;
            #1;
            total++;
            if (bus.state !== exp_st[i]) begin
                $display("FAIL rtype_state cyc=%0d got=%0d want=%0d", i, bus.state, exp_st[i]); bad++;
            end
            if (i == 2) begin
                total++;
                if (bus.alu_op !== 2'b10 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
                    $display("FAIL rtype_exec alu_op=%b src_a=%b src_b=%b want 10/1/00",
                             bus.alu_op, bus.alu_src_a, bus.alu_src_b); bad++;
                end
            end
            if (i == 3) begin
                total++;
                if (bus.reg_write !== 1'b1 || bus.sel_regdst !== 1'b1 || bus.sel_jal !== 1'b0 ||
                    bus.mem_to_reg !== 1'b0) begin
                    $display("FAIL rtype_aluwb rw=%b regdst=%b jal=%b m2r=%b want 1/1/0/0",
                             bus.reg_write, bus.sel_regdst, bus.sel_jal, bus.mem_to_reg); bad++;
                end
            end
            if (i != 4) tick();
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0] exp_st [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       mr     [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.opcode = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = mr[i];
            #1;
            total++;
            if (bus.state !== exp_st[i]) begin
                $display("FAIL lw_state cyc=%0d got=%0d want=%0d", i, bus.state, exp_st[i]); bad++;
            end
            if (i >= 3 && i <= 6) begin
                total++;
                if (bus.mem_read !== 1'b1 || bus.iord !== 1'b1 || bus.mem_write !== 1'b0) begin
                    $display("FAIL lw_memrd cyc=%0d rd=%b iord=%b wr=%b want 1/1/0",
                             i, bus.mem_read, bus.iord, bus.mem_write); bad++;
                end
            end
            if (i == 7) begin
                total++;
                if (bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b1 || bus.sel_regdst !== 1'b0) begin
                    $display("FAIL lw_memwb rw=%b m2r=%b regdst=%b want 1/1/0",
                             bus.reg_write, bus.mem_to_reg, bus.sel_regdst); bad++;
                end
            end
            if (i != 8) tick();
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
        logic       mr     [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = mr[i];
            #1;
            total++;
            if (bus.state !== exp_st[i]) begin
                $display("FAIL sw_state cyc=%0d got=%0d want=%0d", i, bus.state, exp_st[i]); bad++;
            end
            if (i == 3 || i == 4) begin
                total++;
                if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.iord !== 1'b1 ||
                    bus.reg_write !== 1'b0) begin
                    $display("FAIL sw_memwr cyc=%0d wr=%b rd=%b iord=%b rw=%b want 1/0/1/0",
                             i, bus.mem_write, bus.mem_read, bus.iord, bus.reg_write); bad++;
                end
            end
            if (i != 5) tick();
        end
    endtask

    task automatic test_jal();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd12, 4'd0};
        bus.opcode = 6'b000011; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus.state !== exp_st[i]) begin
                $display("FAIL jal_state cyc=%0d got=%0d want=%0d", i, bus.state, exp_st[i]); bad++;
            end
            total++;
            if (bus.sel_jal !== (i == 2)) begin
                $display("FAIL jal_sel_jal cyc=%0d got=%b want=%b", i, bus.sel_jal, (i == 2)); bad++;
            end
            if (i == 2) begin
                total++;
                if (bus.link_wb !== 1'b1 || bus.reg_write !== 1'b1 || bus.pc_write !== 1'b1 ||
                    bus.pc_src !== 2'b10) begin
                    $display("FAIL jal_cycle link=%b rw=%b pcw=%b pc_src=%b want 1/1/1/10",
                             bus.link_wb, bus.reg_write, bus.pc_write, bus.pc_src); bad++;
                end
            end
            if (i != 3) tick();
        end
    endtask

    task automatic test_beq_addi();
        logic [3:0] exp_b [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        logic [3:0] exp_a [5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        bus.mem_ready = 1'b1; bus.opcode = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus.state !== exp_b[i]) begin
                $display("FAIL beq_state cyc=%0d got=%0d want=%0d", i, bus.state, exp_b[i]); bad++;
            end
            if (i == 2) begin
                total++;
                if (bus.pc_write_cond !== 1'b1 || bus.pc_src !== 2'b01 || bus.alu_op !== 2'b01 ||
                    bus.pc_write !== 1'b0) begin
                    $display("FAIL beq_cycle pwc=%b pc_src=%b alu_op=%b pcw=%b want 1/01/01/0",
                             bus.pc_write_cond, bus.pc_src, bus.alu_op, bus.pc_write); bad++;
                end
            end
            if (i != 3) tick();
        end
        bus.opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (bus.state !== exp_a[i]) begin
                $display("FAIL addi_state cyc=%0d got=%0d want=%0d", i, bus.state, exp_a[i]); bad++;
            end
            if (i == 3) begin
                total++;
                if (bus.reg_write !== 1'b1 || bus.sel_regdst !== 1'b0 || bus.mem_to_reg !== 1'b0) begin
                    $display("FAIL addi_wb rw=%b regdst=%b m2r=%b want 1/0/0",
                             bus.reg_write, bus.sel_regdst, bus.mem_to_reg); bad++;
                end
            end
            if (i != 4) tick();
        end
    endtask

    // Two stalled fetch cycles, then a j to return to FETCH.
    task automatic test_fetch_stall();
        logic [3:0] exp_st [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd11, 4'd0};
        logic       mr     [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       exp_ld [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.opcode = 6'b000010;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = mr[i];
            #1;
            total++;
            if (bus.state !== exp_st[i]) begin
                $display("FAIL stall_state cyc=%0d got=%0d want=%0d", i, bus.state, exp_st[i]); bad++;
            end
            total++;
            if (bus.ir_write !== exp_ld[i] || (i != 4 && bus.pc_write !== exp_ld[i])) begin
                $display("FAIL stall_load cyc=%0d ir_write=%b pc_write=%b want=%b",
                         i, bus.ir_write, bus.pc_write, exp_ld[i]); bad++;
            end
            if (i == 4) begin
                total++;
                if (bus.pc_write !== 1'b1 || bus.pc_src !== 2'b10) begin
                    $display("FAIL jump_cycle pcw=%b pc_src=%b want 1/10", bus.pc_write, bus.pc_src); bad++;
                end
            end
            if (i != 5) tick();
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd13, 4'd0};
        bus.opcode = 6'b111111; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus.state !== exp_st[i] || bus.illegal !== (i == 2)) begin
                $display("FAIL illegal_seq cyc=%0d state=%0d illegal=%b want %0d/%b",
                         i, bus.state, bus.illegal, exp_st[i], (i == 2)); bad++;
            end
            if (i == 1 || i == 2) begin
                total++;
                if (bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0 || bus.pc_write !== 1'b0) begin
                    $display("FAIL illegal_strobes cyc=%0d rw=%b mw=%b pcw=%b want 0/0/0",
                             i, bus.reg_write, bus.mem_write, bus.pc_write); bad++;
                end
            end
            if (i != 3) tick();
        end
    endtask

    task automatic test_reset_memwr();
        bus.opcode = 6'b101011; bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0; #1;
        total++;
        if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
            $display("FAIL memwr_reach state=%0d mem_write=%b want 5/1", bus.state, bus.mem_write); bad++;
        end
        rst = 1'b1; #1;
        total++;
        if (all_outs() !== 23'd0) begin
            $display("FAIL reset_mid_memwr got=%h want=0", all_outs()); bad++;
        end
        tick();
        rst = 1'b0; bus.mem_ready = 1'b1; #1;
        total++;
        if (bus.state !== 4'd0 || bus.mem_write !== 1'b0) begin
            $display("FAIL reset_memwr_release state=%0d mem_write=%b want 0/0",
                     bus.state, bus.mem_write); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_stall();
        test_jal();
        test_beq_addi();
        test_fetch_stall();
        test_illegal();
        test_reset_memwr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style main control state machine for the multicycle MIPS core. It sequences the shared datapath through fetch, decode, execute, memory and writeback. It drives the register-destination selects (`sel_regdst`, `sel_jal`) that feed the 3:1 write-register mux, plus every other datapath enable. It tolerates variable-latency memory through a `mem_ready` handshake.

## Interface
- No parameters; opcodes are fixed constants.
- `clk` input 1: the only clock; everything updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: IR[31:26]; sampled in DECODE and MEMADR.
- `mem_ready` input 1: memory access completes this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU zero (branch).
- `iord` output 1: memory address source; 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `ir_write` output 1: instruction register load.
- `mem_to_reg` output 1: write data source; 1 = MDR, 0 = ALUOut.
- `link_wb` output 1: write data = PC (jal link); overrides `mem_to_reg`.
- `sel_regdst` output 1: write register; 1 = rd, 0 = rt.
- `sel_jal` output 1: write register = $31.
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: 0 = PC, 1 = A.
- `alu_src_b` output 2: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op` output 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `pc_src` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` output 1: one-cycle pulse on an undefined opcode.
- `state` output 4: current state encoding, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, jal 000011.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12, ILLEGAL 13. Codes 14 and 15 go to FETCH.
- Any output not listed for a state is 0.
- FETCH
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready; this is the only Mealy term.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state: R-type→EXEC, lw/sw→MEMADR, beq→BRANCH, addi→ADDIEX, j→JUMP, jal→JAL, other→ILLEGAL.
- MEMADR
  - Drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - lw→MEMRD; sw→MEMWR.
- MEMRD: mem_read=1, iord=1; holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, sel_regdst=0; then FETCH.
- MEMWR: mem_write=1, iord=1; holds until mem_ready, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB.
- ALUWB: reg_write=1, sel_regdst=1, mem_to_reg=0; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
- ADDIWB: reg_write=1, sel_regdst=0; then FETCH.
- JUMP: pc_write=1, pc_src=10; then FETCH.
- JAL
  - Drives pc_write=1, pc_src=10, reg_write=1, sel_jal=1, link_wb=1; then FETCH.
  - The PC already holds PC+4, so the link value is correct.
- ILLEGAL: illegal=1, no write enables; then FETCH.
- Invariants
  - sel_jal=1 only in JAL.
  - reg_write=1 only in MEMWB, ALUWB, ADDIWB, JAL.
  - mem_read and mem_write are never both 1.

## Timing
- Reset
  - With rst=1 at a rising edge, state becomes FETCH.
  - While rst=1, every output is forced to 0, including Mealy terms and `state`.
  - Reset mid-instruction (even mid-MEMWR with mem_ready low) aborts without any write strobe in the reset cycle.
- Latency from FETCH entry, with mem_ready=1 on the first access cycle:
  - beq, j, jal: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle mem_ready is held low in FETCH, MEMRD or MEMWR adds one cycle.
- Write enables
  - Writebacks assert reg_write for exactly one cycle.
  - pc_write and ir_write assert once per fetch.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- The opcode is sampled only at the DECODE→X and MEMADR→X transitions; changes at other times have no effect.

## Test plan
- Reset behaviour: drive rst=1 for 2 cycles mid-EXEC, then release → all outputs 0 during reset, state=0 one cycle later with mem_read=1.
- R-type, opcode 000000, mem_ready=1 → states 0,1,6,7,0; ALUWB cycle shows reg_write=1, sel_regdst=1, sel_jal=0.
- lw with mem_ready low for 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4,0; MEMWB shows mem_to_reg=1, sel_regdst=0.
- jal, opcode 000011 → JAL cycle shows sel_jal=1, link_wb=1, reg_write=1, pc_write=1, pc_src=10; 3 cycles total.
- Fetch stall: mem_ready=0 for 2 cycles in FETCH → ir_write and pc_write stay 0, then both 1 for exactly one cycle with mem_ready=1.
- Illegal opcode 111111 → states 0,1,13,0; illegal high for 1 cycle; reg_write, mem_write, pc_write never 1.
